// File: rtl/board_io_pkg.sv
// Shared constants and types for the board push-button / switch input path.
// Also used by the top-level wiring for default debounce depth and button count.
package board_io_pkg;

  localparam int DEBOUNCE_CNT_W = 4;
  localparam int DEF_STABLE_CNT = 4;
  localparam int NUM_BUTTONS    = 5;
  localparam int MAX_STABLE_CNT = (1 << DEBOUNCE_CNT_W) - 1;

  typedef logic [DEBOUNCE_CNT_W-1:0] dbc_cnt_t;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } chan_out_t;

  // Terminal count of the stability counter; out-of-range depths are clamped
  // so the counter can never wrap.
  function automatic dbc_cnt_t cnt_last(input int stable_cnt);
    int clamped;
    if (stable_cnt < 1) begin
      clamped = 1;
    end else if (stable_cnt > MAX_STABLE_CNT) begin
      clamped = MAX_STABLE_CNT;
    end else begin
      clamped = stable_cnt;
    end
    return dbc_cnt_t'(clamped - 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, level and edge pulses.
// Latency 2 clk + STABLE_CNT ticks; no backpressure, counter advances only when tick is high.
module debounce_chan
  import board_io_pkg::*;
#(
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      tick,
  input  logic      raw_in,
  output chan_out_t chan_out
);

  localparam dbc_cnt_t CNT_LAST = cnt_last(STABLE_CNT);

  logic     s1_q, s1_d;
  logic     s2_q, s2_d;
  logic     level_q, level_d;
  logic     rise_q, rise_d;
  logic     fall_q, fall_d;
  dbc_cnt_t cnt_q, cnt_d;

  always_comb begin
    s1_d    = raw_in;
    s2_d    = s1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (tick) begin
      if (s2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        // Pulses are registered alongside level so they line up with it.
        level_d = s2_q;
        cnt_d   = '0;
        rise_d  = s2_q;
        fall_d  = ~s2_q;
      end else begin
        cnt_d = cnt_q + dbc_cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= RESET_LEVEL;
      s2_q    <= RESET_LEVEL;
      cnt_q   <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign chan_out.level = level_q;
  assign chan_out.rise  = rise_q;
  assign chan_out.fall  = fall_q;

endmodule

// File: rtl/btn_debounce.sv
// N-channel button/switch debouncer sampled on rising edges of a divider bit.
// Latency 2 clk + STABLE_CNT ticks; no backpressure, outputs hold while div_bit is static.
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int N           = NUM_BUTTONS,
  parameter int STABLE_CNT  = DEF_STABLE_CNT,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         div_bit,
  input  logic [N-1:0] raw_in,
  output logic [N-1:0] level_out,
  output logic [N-1:0] rise_pulse,
  output logic [N-1:0] fall_pulse
);

  logic div_q, div_d;
  logic tick;

  always_comb begin
    div_d = div_bit;
  end

  // Resetting to 1 suppresses a spurious tick if div_bit is already high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= 1'b1;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = div_bit & ~div_q;

  chan_out_t [N-1:0] chan_w;

  for (genvar i = 0; i < N; i++) begin : g_chan
    debounce_chan #(
      .STABLE_CNT  (STABLE_CNT),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .raw_in   (raw_in[i]),
      .chan_out (chan_w[i])
    );

    assign level_out[i]  = chan_w[i].level;
    assign rise_pulse[i] = chan_w[i].rise;
    assign fall_pulse[i] = chan_w[i].fall;
  end

endmodule
